anita_rate_scaler: RTL and testbench

Event-rate scaler with an integrated 1 kHz update-tick generator, used in the scaler subsystem to count trigger and antenna discriminator outputs on the 33 MHz system clock. Each instance counts rising edges of one trigger line. The count can optionally be prescaled. On every tick the count for the closed interval is latched onto a stable output, and a fresh interval starts. The tick is also exported so that bank-switching logic and sibling scalers can align to the same update boundary.

---
 rtl/anita_rate_scaler.sv | 99 +++++++++
 tb/tb_anita_rate_scaler.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/anita_rate_scaler.sv
`default_nettype none
// ============================================================================
// anita_rate_scaler : rising-edge event scaler with built-in update tick.
// Build option: SCALER_SATURATE_EN (counter holds at max instead of wrapping).
// Revision: 1.0
// ============================================================================
module anita_rate_scaler #(
    parameter int WIDTH    = 16,
    parameter int PRESCALE = 0,
    parameter int CLK_DIV  = 33000
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             count_i,
    output logic [WIDTH-1:0] scaler_o,
    output logic             khz_clk_o
);

    localparam int c_div_w = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [c_div_w-1:0] c_div_last = c_div_w'(CLK_DIV - 1);

    logic [c_div_w-1:0] r_div;
    logic               r_khz;
    logic               r_count_q;
    logic [WIDTH-1:0]   r_events;
    logic [WIDTH-1:0]   r_scaler;
    logic               w_edge;
    logic               w_inc;
    logic               w_first;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_div <= '0;
            r_khz <= 1'b0;
        end else if (r_div == c_div_last) begin
            r_div <= '0;
            r_khz <= 1'b1;
        end else begin
            r_div <= r_div + 1'b1;
            r_khz <= 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_count_q <= 1'b0;
        end else begin
            r_count_q <= count_i;
        end
    end

    assign w_edge = count_i & ~r_count_q;

    // w_first: an edge coinciding with the tick seeds the fresh interval
    generate
        if (PRESCALE > 0) begin : g_prescale
            logic [PRESCALE-1:0] r_presc;

            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    r_presc <= '0;
                end else if (r_khz) begin
                    r_presc <= PRESCALE'(w_edge);
                end else if (w_edge) begin
                    r_presc <= r_presc + 1'b1;
                end
            end

            assign w_inc   = w_edge & (&r_presc);
            assign w_first = 1'b0;
        end else begin : g_no_prescale
            assign w_inc   = w_edge;
            assign w_first = w_edge;
        end
    endgenerate

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_events <= '0;
            r_scaler <= '0;
        end else if (r_khz) begin
            r_scaler <= r_events;
            r_events <= WIDTH'(w_first);
        end else if (w_inc) begin
`ifdef SCALER_SATURATE_EN
            if (!(&r_events)) begin
                r_events <= r_events + 1'b1;
            end
`else
            r_events <= r_events + 1'b1;
`endif
        end
    end

    assign scaler_o  = r_scaler;
    assign khz_clk_o = r_khz;

endmodule
`default_nettype wire

// File: tb/tb_anita_rate_scaler.sv
`default_nettype none
// ============================================================================
// tb_anita_rate_scaler : directed table-driven bench for anita_rate_scaler.
// Revision: 1.0
// ============================================================================
module tb_anita_rate_scaler;

    logic        clk;
    logic        rst;
    logic        count;
    logic        khz_div;
    logic        khz_cnt;
    logic        khz_pre;
    logic        khz_ovf;
    logic [15:0] scaler_div;
    logic [15:0] scaler_cnt;
    logic [15:0] scaler_pre;
    logic [3:0]  scaler_ovf;
    int          cyc;
    int          n_checks;
    int          n_errors;

`ifdef SCALER_SATURATE_EN
    localparam int OVF20 = 15;
    localparam int OVF16 = 15;
`else
    localparam int OVF20 = 4;
    localparam int OVF16 = 0;
`endif

    typedef struct {
        int edges;
        int exp_cnt;
        int exp_pre;
        int exp_ovf;
    } vec_t;

    vec_t vecs[7];

    anita_rate_scaler #(.WIDTH(16), .PRESCALE(0), .CLK_DIV(10)) u_div (
        .clk_i(clk), .rst_i(rst), .count_i(count),
        .scaler_o(scaler_div), .khz_clk_o(khz_div)
    );
    anita_rate_scaler #(.WIDTH(16), .PRESCALE(0), .CLK_DIV(100)) u_cnt (
        .clk_i(clk), .rst_i(rst), .count_i(count),
        .scaler_o(scaler_cnt), .khz_clk_o(khz_cnt)
    );
    anita_rate_scaler #(.WIDTH(16), .PRESCALE(2), .CLK_DIV(100)) u_pre (
        .clk_i(clk), .rst_i(rst), .count_i(count),
        .scaler_o(scaler_pre), .khz_clk_o(khz_pre)
    );
    anita_rate_scaler #(.WIDTH(4), .PRESCALE(0), .CLK_DIV(100)) u_ovf (
        .clk_i(clk), .rst_i(rst), .count_i(count),
        .scaler_o(scaler_ovf), .khz_clk_o(khz_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle index: number of rising edges since reset release.
    always @(posedge clk) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic goto(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulses(input int start, input int n);
        for (int k = 0; k < n; k++) begin
            goto(start + 2 * k);
            count = 1'b1;
            goto(start + 2 * k + 1);
            count = 1'b0;
        end
    endtask

    task automatic check_all(input string tag, input int ec, input int ep, input int eo);
        check({tag, "_cnt"}, 32'(scaler_cnt), ec);
        check({tag, "_pre"}, 32'(scaler_pre), ep);
        check({tag, "_ovf"}, 32'(scaler_ovf), eo);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        vecs[0] = '{7,  7,  1, 7};
        vecs[1] = '{0,  0,  0, 0};
        vecs[2] = '{10, 10, 2, 10};
        vecs[3] = '{12, 12, 3, 12};
        vecs[4] = '{20, 20, 5, OVF20};
        vecs[5] = '{16, 16, 4, OVF16};
        vecs[6] = '{15, 15, 3, 15};

        rst   = 1'b1;
        count = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        check("rst_khz", 32'(khz_cnt), 0);
        check("rst_khz_div", 32'(khz_div), 0);
        check_all("rst", 0, 0, 0);

        // Divider: one-cycle pulses at 10, 20, 30; scaler idle before first update
        for (int c = 1; c <= 35; c++) begin
            goto(c);
            check("div_khz", 32'(khz_div), 32'(c % 10 == 0));
            if (c <= 10) check("div_scaler", 32'(scaler_div), 0);
        end

        goto(101);
        check("first_cnt", 32'(scaler_cnt), 0);

        for (int i = 0; i < 7; i++) begin
            int base;
            base = 100 * (i + 1);
            pulses(base + 2, vecs[i].edges);
            goto(base + 100);
            check("tick_hi", 32'(khz_cnt), 1);
            goto(base + 101);
            check("tick_lo", 32'(khz_cnt), 0);
            check_all("vec", vecs[i].exp_cnt, vecs[i].exp_pre, vecs[i].exp_ovf);
        end

        // Level held high for 50 cycles is a single event
        goto(802);
        count = 1'b1;
        goto(852);
        count = 1'b0;
        goto(901);
        check_all("held", 1, 0, 1);

        // Edge coinciding with the tick belongs to the new interval
        pulses(902, 2);
        goto(1000);
        count = 1'b1;
        goto(1001);
        count = 1'b0;
        check_all("bnd_prev", 2, 0, 2);
        pulses(1004, 3);
        goto(1101);
        check_all("bnd_next", 4, 1, 4);

        // Reset mid-interval after 5 edges
        pulses(1102, 5);
        goto(1130);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst   = 1'b0;
        count = 1'b1;
        check_all("mid_rst", 0, 0, 0);
        check("mid_rst_khz", 32'(khz_cnt), 0);
        goto(1);
        count = 1'b0;
        pulses(3, 2);
        goto(10);
        check("post_rst_div", 32'(khz_div), 1);
        goto(99);
        check("post_rst_early", 32'(khz_cnt), 0);
        goto(100);
        check("post_rst_tick", 32'(khz_cnt), 1);
        goto(101);
        check_all("post_rst", 3, 0, 3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
